// File: rtl/operand_bypass_unit_if.sv
// Bundles the decode-side request, the forwarding sources and the hazard /
// debug outputs of operand_bypass_unit. Clock and reset stay outside.
interface operand_bypass_unit_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic                        validD;
  logic [ADDR_W-1:0]           destAddD;
  logic                        RegWriteD;
  logic                        MemToRegD;
  logic [NUM_SRC*ADDR_W-1:0]   srcAddD;
  logic [NUM_SRC-1:0]          srcUsedD;
  logic [NUM_SRC*DATA_W-1:0]   regDataD;
  logic [DATA_W-1:0]           alu_resultE;
  logic [DATA_W-1:0]           alu_resultM;
  logic [DATA_W-1:0]           MemReadDataM;
  logic [DATA_W-1:0]           ResultW;
  logic                        flushD;
  logic                        stall_clr;
  logic [NUM_SRC*DATA_W-1:0]   operandD;
  logic                        stallD;
  logic                        bubbleE;
  logic [CNT_W-1:0]            stall_cnt;

  modport master (
    output validD, destAddD, RegWriteD, MemToRegD, srcAddD, srcUsedD,
           regDataD, alu_resultE, alu_resultM, MemReadDataM, ResultW,
           flushD, stall_clr,
    input  operandD, stallD, bubbleE, stall_cnt
  );

  modport slave (
    input  validD, destAddD, RegWriteD, MemToRegD, srcAddD, srcUsedD,
           regDataD, alu_resultE, alu_resultM, MemReadDataM, ResultW,
           flushD, stall_clr,
    output operandD, stallD, bubbleE, stall_cnt
  );
endinterface

// File: rtl/operand_bypass_unit.sv
// Operand forwarding and load-use hazard tracking between decode and execute.
// Keeps its own E/M/W records of {valid, dest, RegWrite, MemToReg}, forwards
// each source from the youngest matching stage, stalls one cycle on a
// load-use hazard and counts stall cycles (saturating) for debug readout.
module operand_bypass_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_SRC  = 2,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  operand_bypass_unit_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic              reg_write;
    logic              mem_to_reg;
  } stage_rec_t;

  stage_rec_t        e_q, m_q, w_q;
  stage_rec_t        e_d;
  logic [NUM_SRC-1:0] load_hit;
  logic              stall;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // A stage can feed a source only if it really writes that register and the
  // source is actually read; r0 is hard-wired when ZERO_REG is set.
  function automatic logic stage_hit(input stage_rec_t s, input logic used,
                                     input logic [ADDR_W-1:0] src);
    logic zero_blk;
    zero_blk = (ZERO_REG != 0) && (src == '0);
    return s.valid && s.reg_write && used && (s.dest == src) && !zero_blk;
  endfunction

  // Per-source match and priority mux: E (non-load) > M > W > register file.
  // An E-stage load match falls through; that operand is don't-care while
  // the decode slot is held by the stall.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [ADDR_W-1:0] src;
    logic [DATA_W-1:0] rf_data;
    logic              used;
    logic              hit_e, hit_m, hit_w;
    logic [DATA_W-1:0] op;

    assign src     = bus.srcAddD[gi*ADDR_W +: ADDR_W];
    assign rf_data = bus.regDataD[gi*DATA_W +: DATA_W];
    assign used    = bus.srcUsedD[gi];
    assign hit_e   = stage_hit(e_q, used, src);
    assign hit_m   = stage_hit(m_q, used, src);
    assign hit_w   = stage_hit(w_q, used, src);

    assign load_hit[gi] = hit_e && e_q.mem_to_reg;

    // Select the forwarded value for this source.
    always_comb begin
      op = rf_data;
      if (hit_e && !e_q.mem_to_reg) begin
        op = bus.alu_resultE;
      end else if (hit_m) begin
        op = m_q.mem_to_reg ? bus.MemReadDataM : bus.alu_resultM;
      end else if (hit_w) begin
        op = bus.ResultW;
      end
    end

    assign bus.operandD[gi*DATA_W +: DATA_W] = op;
  end

  // Flush kills the decode instruction, so it can never be the one stalling.
  assign stall       = bus.validD && !bus.flushD && (|load_hit);
  assign bus.stallD  = stall;
  assign bus.bubbleE = stall || bus.flushD || !bus.validD;
  assign bus.stall_cnt = cnt_q;

  // Next E record: the decode instruction when it issues, otherwise a bubble.
  always_comb begin
    e_d = '0;
    if (bus.validD && !bus.flushD && !stall) begin
      e_d.valid      = 1'b1;
      e_d.dest       = bus.destAddD;
      e_d.reg_write  = bus.RegWriteD;
      e_d.mem_to_reg = bus.MemToRegD;
    end
  end

  // Advance the E -> M -> W records every cycle; reset discards them all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      w_q <= m_q;
      m_q <= e_q;
      e_q <= e_d;
    end
  end

  // Stall counter next state: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.stall_clr) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Bench for operand_bypass_unit: directed scenarios plus randomized traffic
// checked against a stage-list reference model.
module tb_operand_bypass_unit;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NS = 2;
  localparam int ZR = 1;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  operand_bypass_unit_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .CNT_W(CW)) bus ();

  operand_bypass_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS), .ZERO_REG(ZR), .CNT_W(CW))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: index 0 = E, 1 = M, 2 = W.
  logic          m_v[3];
  logic          m_rw[3];
  logic          m_ld[3];
  logic [AW-1:0] m_dst[3];
  int            m_cnt;

  function automatic logic [DW-1:0] ref_operand(input int i, output logic haz);
    logic [AW-1:0] s;
    s   = bus.srcAddD[i*AW +: AW];
    haz = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (m_v[k] && m_rw[k] && bus.srcUsedD[i] && (m_dst[k] == s) && !(ZR != 0 && s == 0)) begin
        if (k == 0 && m_ld[0]) begin
          haz = 1'b1;
          continue;
        end
        if (k == 0) return bus.alu_resultE;
        if (k == 1) return m_ld[1] ? bus.MemReadDataM : bus.alu_resultM;
        return bus.ResultW;
      end
    end
    return bus.regDataD[i*DW +: DW];
  endfunction

  function automatic logic ref_stall();
    logic h;
    logic any;
    logic [DW-1:0] unused_v;
    any = 1'b0;
    for (int i = 0; i < NS; i++) begin
      unused_v = ref_operand(i, h);
      any = any | h;
    end
    return bus.validD && !bus.flushD && any;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 0; m_rw[k] = 0; m_ld[k] = 0; m_dst[k] = '0;
    end
    m_cnt = 0;
  endtask

  task automatic tick();
    logic stl, iss;
    stl = ref_stall();
    iss = bus.validD && !bus.flushD && !stl;
    @(posedge clk);
    #1;
    for (int k = 2; k > 0; k--) begin
      m_v[k] = m_v[k-1]; m_rw[k] = m_rw[k-1]; m_ld[k] = m_ld[k-1]; m_dst[k] = m_dst[k-1];
    end
    m_v[0]   = iss;
    m_rw[0]  = iss ? bus.RegWriteD : 1'b0;
    m_ld[0]  = iss ? bus.MemToRegD : 1'b0;
    m_dst[0] = iss ? bus.destAddD : '0;
    if (bus.stall_clr) m_cnt = 0;
    else if (stl && m_cnt < CMAX) m_cnt = m_cnt + 1;
  endtask

  task automatic drive_idle();
    bus.validD = 0; bus.flushD = 0; bus.stall_clr = 0; bus.srcUsedD = '0;
    bus.RegWriteD = 0; bus.MemToRegD = 0; bus.destAddD = '0; bus.srcAddD = '0;
  endtask

  task automatic issue(input logic [AW-1:0] dest, input logic ld);
    bus.validD = 1; bus.flushD = 0; bus.destAddD = dest; bus.RegWriteD = 1;
    bus.MemToRegD = ld; bus.srcUsedD = '0;
    tick();
  endtask

  task automatic read_src0(input logic [AW-1:0] s);
    bus.validD = 1; bus.flushD = 0; bus.RegWriteD = 0; bus.MemToRegD = 0;
    bus.srcAddD = {4'd0, s}; bus.srcUsedD = 2'b01;
  endtask

  task automatic drain();
    drive_idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 0;
    drive_idle();
    bus.regDataD = 32'hAAAA_5555;
    #1;
    n_cmp++; if (bus.stallD !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", bus.stallD); end
    n_cmp++; if (bus.bubbleE !== 1'b1) begin n_bad++; $display("FAIL rst_bubble: got %b want 1", bus.bubbleE); end
    n_cmp++; if (bus.stall_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", bus.stall_cnt); end
    n_cmp++; if (bus.operandD !== 32'hAAAA_5555) begin n_bad++; $display("FAIL rst_op: got %h want AAAA5555", bus.operandD); end
    model_clear();
    @(negedge clk);
    reset = 1;
    #1;
  endtask

  task automatic test_e_forward();
    drain();
    issue(4'd3, 1'b0);
    read_src0(4'd3);
    bus.alu_resultE = 16'h1234; bus.regDataD = '0;
    #1;
    n_cmp++; if (bus.operandD[15:0] !== 16'h1234) begin n_bad++; $display("FAIL e_fwd_op: got %h want 1234", bus.operandD[15:0]); end
    n_cmp++; if (bus.stallD !== 1'b0) begin n_bad++; $display("FAIL e_fwd_stall: got %b want 0", bus.stallD); end
    tick();
  endtask

  task automatic test_load_use();
    drain();
    issue(4'd5, 1'b1);
    read_src0(4'd5);
    bus.alu_resultM = 16'h1111; bus.MemReadDataM = 16'hBEEF; bus.regDataD = 32'h0000_5555;
    #1;
    n_cmp++; if (bus.stallD !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", bus.stallD); end
    n_cmp++; if (bus.bubbleE !== 1'b1) begin n_bad++; $display("FAIL lu_bubble: got %b want 1", bus.bubbleE); end
    tick();
    n_cmp++; if (bus.operandD[15:0] !== 16'hBEEF) begin n_bad++; $display("FAIL lu_op: got %h want BEEF", bus.operandD[15:0]); end
    n_cmp++; if (bus.stallD !== 1'b0) begin n_bad++; $display("FAIL lu_stall2: got %b want 0", bus.stallD); end
    n_cmp++; if (bus.bubbleE !== 1'b0) begin n_bad++; $display("FAIL lu_bubble2: got %b want 0", bus.bubbleE); end
    tick();
  endtask

  task automatic test_priority();
    drain();
    issue(4'd2, 1'b0);
    issue(4'd2, 1'b0);
    issue(4'd2, 1'b0);
    bus.validD = 1; bus.RegWriteD = 0; bus.MemToRegD = 0;
    bus.srcAddD = {4'd2, 4'd7}; bus.srcUsedD = 2'b11;
    bus.alu_resultE = 16'h0001; bus.alu_resultM = 16'h0002; bus.ResultW = 16'h0003;
    bus.regDataD = 32'h00AA_0077;
    #1;
    n_cmp++; if (bus.operandD[31:16] !== 16'h0001) begin n_bad++; $display("FAIL prio_e: got %h want 0001", bus.operandD[31:16]); end
    n_cmp++; if (bus.operandD[15:0] !== 16'h0077) begin n_bad++; $display("FAIL prio_nomatch: got %h want 0077", bus.operandD[15:0]); end
    bus.validD = 0;
    tick();
    bus.validD = 1;
    #1;
    n_cmp++; if (bus.operandD[31:16] !== 16'h0002) begin n_bad++; $display("FAIL prio_m: got %h want 0002", bus.operandD[31:16]); end
    bus.validD = 0;
    tick();
    #1;
    n_cmp++; if (bus.operandD[31:16] !== 16'h0003) begin n_bad++; $display("FAIL prio_w: got %h want 0003", bus.operandD[31:16]); end
  endtask

  task automatic test_zero_reg();
    drain();
    issue(4'd0, 1'b0);
    drive_idle();
    tick();
    tick();
    read_src0(4'd0);
    bus.ResultW = 16'hFFFF; bus.regDataD = '0;
    #1;
    n_cmp++; if (bus.operandD[15:0] !== 16'h0000) begin n_bad++; $display("FAIL zero_op: got %h want 0000", bus.operandD[15:0]); end
    n_cmp++; if (bus.stallD !== 1'b0) begin n_bad++; $display("FAIL zero_stall: got %b want 0", bus.stallD); end
    issue(4'd0, 1'b1);
    read_src0(4'd0);
    #1;
    n_cmp++; if (bus.stallD !== 1'b0) begin n_bad++; $display("FAIL zero_load_stall: got %b want 0", bus.stallD); end
    tick();
  endtask

  task automatic test_flush();
    drain();
    issue(4'd5, 1'b1);
    read_src0(4'd5);
    bus.RegWriteD = 1; bus.destAddD = 4'd6; bus.flushD = 1;
    #1;
    n_cmp++; if (bus.stallD !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", bus.stallD); end
    n_cmp++; if (bus.bubbleE !== 1'b1) begin n_bad++; $display("FAIL flush_bubble: got %b want 1", bus.bubbleE); end
    tick();
    read_src0(4'd6);
    bus.alu_resultE = 16'h7777; bus.regDataD = 32'h0000_0606;
    #1;
    n_cmp++; if (bus.operandD[15:0] !== 16'h0606) begin n_bad++; $display("FAIL flush_e_invalid: got %h want 0606", bus.operandD[15:0]); end
    tick();
  endtask

  task automatic test_counter();
    drain();
    bus.stall_clr = 1;
    tick();
    bus.stall_clr = 0;
    n_cmp++; if (bus.stall_cnt !== 2'd0) begin n_bad++; $display("FAIL cnt_clr0: got %0d want 0", bus.stall_cnt); end
    for (int k = 0; k < 5; k++) begin
      issue(4'd5, 1'b1);
      read_src0(4'd5);
      tick();
      n_cmp++;
      if (bus.stall_cnt !== CW'((k + 1 > CMAX) ? CMAX : k + 1)) begin
        n_bad++; $display("FAIL cnt_step%0d: got %0d want %0d", k, bus.stall_cnt, (k + 1 > CMAX) ? CMAX : k + 1);
      end
    end
    n_cmp++; if (bus.stall_cnt !== 2'd3) begin n_bad++; $display("FAIL cnt_sat: got %0d want 3", bus.stall_cnt); end
    drive_idle();
    bus.stall_clr = 1;
    tick();
    bus.stall_clr = 0;
    n_cmp++; if (bus.stall_cnt !== 2'd0) begin n_bad++; $display("FAIL cnt_clr: got %0d want 0", bus.stall_cnt); end
    issue(4'd5, 1'b1);
    read_src0(4'd5);
    tick();
    issue(4'd5, 1'b1);
    read_src0(4'd5);
    bus.regDataD = 32'h0000_4321;
    #1;
    n_cmp++; if (bus.stallD !== 1'b1) begin n_bad++; $display("FAIL mid_pre_stall: got %b want 1", bus.stallD); end
    reset = 0;
    #1;
    n_cmp++; if (bus.stallD !== 1'b0) begin n_bad++; $display("FAIL mid_rst_stall: got %b want 0", bus.stallD); end
    n_cmp++; if (bus.stall_cnt !== 2'd0) begin n_bad++; $display("FAIL mid_rst_cnt: got %0d want 0", bus.stall_cnt); end
    n_cmp++; if (bus.operandD[15:0] !== 16'h4321) begin n_bad++; $display("FAIL mid_rst_op: got %h want 4321", bus.operandD[15:0]); end
    model_clear();
    #2;
    reset = 1;
    #1;
  endtask

  task automatic test_random();
    logic h;
    logic [DW-1:0] exp;
    logic exp_stl;
    for (int c = 0; c < 400; c++) begin
      bus.validD      = ($urandom_range(3) != 0);
      bus.flushD      = ($urandom_range(7) == 0);
      bus.stall_clr   = ($urandom_range(15) == 0);
      bus.destAddD    = AW'($urandom_range(3));
      bus.RegWriteD   = ($urandom_range(3) != 0);
      bus.MemToRegD   = ($urandom_range(2) == 0);
      bus.srcAddD     = {AW'($urandom_range(3)), AW'($urandom_range(3))};
      bus.srcUsedD    = NS'($urandom_range(3));
      bus.regDataD    = {DW'($urandom), DW'($urandom)};
      bus.alu_resultE = DW'($urandom);
      bus.alu_resultM = DW'($urandom);
      bus.MemReadDataM = DW'($urandom);
      bus.ResultW     = DW'($urandom);
      #1;
      exp_stl = ref_stall();
      for (int i = 0; i < NS; i++) begin
        exp = ref_operand(i, h);
        if (!(h && exp_stl)) begin
          n_cmp++;
          if (bus.operandD[i*DW +: DW] !== exp) begin
            n_bad++; $display("FAIL rnd_op%0d cyc %0d: got %h want %h", i, c, bus.operandD[i*DW +: DW], exp);
          end
        end
      end
      n_cmp++; if (bus.stallD !== exp_stl) begin n_bad++; $display("FAIL rnd_stall cyc %0d: got %b want %b", c, bus.stallD, exp_stl); end
      n_cmp++;
      if (bus.bubbleE !== (exp_stl || bus.flushD || !bus.validD)) begin
        n_bad++; $display("FAIL rnd_bubble cyc %0d: got %b want %b", c, bus.bubbleE, exp_stl || bus.flushD || !bus.validD);
      end
      n_cmp++; if (bus.stall_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", c, bus.stall_cnt, m_cnt); end
      tick();
    end
  endtask

  initial begin
    drive_idle();
    bus.regDataD = '0; bus.alu_resultE = '0; bus.alu_resultM = '0;
    bus.MemReadDataM = '0; bus.ResultW = '0;
    model_clear();
    #12;
    test_reset();
    test_e_forward();
    test_load_use();
    test_priority();
    test_zero_reg();
    test_flush();
    test_counter();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/operand_bypass_unit.md
# operand_bypass_unit

Parametrised operand-forwarding and hazard-tracking block for the pipelined CPU datapath. It sits between the decode-stage register-file read ports and the execute pipeline register, and supplies `NUM_SRC` operands per cycle. It tracks the destination/write-enable/load flags of the instructions in E, M and W internally and forwards from all three stages, so the control unit no longer computes forwarding selects. It detects load-use hazards and stalls on them, supports flushing the issuing slot into a bubble, and keeps a saturating stall counter for debug readout over UART.

## Interface
Parameters:
- `DATA_W`, 16: operand/result width.
- `ADDR_W`, 4: register address width.
- `NUM_SRC`, 2: number of source operands per instruction.
- `ZERO_REG`, 1: when 1, register address 0 is never forwarded and never matches as a hazard.
- `CNT_W`, 16: stall counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `validD` in 1: the decode slot holds a real instruction.
- `destAddD` in `ADDR_W`: destination of the decode instruction.
- `RegWriteD` in 1: the decode instruction writes the register file.
- `MemToRegD` in 1: the decode instruction is a load.
- `srcAddD` in `NUM_SRC*ADDR_W`: source addresses; slice i is `[i*ADDR_W +: ADDR_W]`.
- `srcUsedD` in `NUM_SRC`: source i is actually read.
- `regDataD` in `NUM_SRC*DATA_W`: register-file read data.
- `alu_resultE` in `DATA_W`: combinational ALU output of E.
- `alu_resultM` in `DATA_W`: ALU result held in M.
- `MemReadDataM` in `DATA_W`: combinational memory read data in M.
- `ResultW` in `DATA_W`: final write-back value.
- `flushD` in 1: kill the decode instruction, for example on a taken branch.
- `stall_clr` in 1: synchronous clear of the stall counter.
- `operandD` out `NUM_SRC*DATA_W`: forwarded operands.
- `stallD` out 1: load-use hazard; freezes PC and the decode register.
- `bubbleE` out 1: a bubble is being inserted into E this cycle.
- `stall_cnt` out `CNT_W`: saturating count of stall cycles.

## Operation
- **Internal stage records.** E, M and W each hold {valid, dest, RegWrite, MemToReg}.
- **Record updates on each clock:**
  - W <= M.
  - M <= E.
  - E <= D fields if `validD & ~flushD & ~stallD`; otherwise E <= bubble (valid=0, all flags 0).
- **Stage match.** Stage S matches source i when all of the following hold:
  - S.valid & S.RegWrite.
  - `srcUsedD[i]`.
  - S.dest == src i.
  - not (`ZERO_REG` and src i == 0).
- **Operand priority per source** (highest first):
  1. E match and E not a load -> `alu_resultE`.
  2. M match -> `MemReadDataM` if M.MemToReg, else `alu_resultM`.
  3. W match -> `ResultW`.
  4. Otherwise -> `regDataD` slice.
- **E-stage load match.** An E match with E.MemToReg is a load-use hazard. The operand then falls through to priority 2–4; its value is don't-care while stalled.
- **Stall.** `stallD` = `validD & ~flushD` & (any source has an E-stage load match). It is combinational.
- **Bubble.** `bubbleE` = `stallD | flushD | ~validD`.
- **Single-cycle stall.** After one stall cycle the load is in M and is forwarded from `MemReadDataM`. A load-use stall therefore lasts exactly one cycle.
- **Flush priority.** `flushD` overrides the hazard: `stallD`=0 and a bubble is inserted.
- **Stall counter.**
  - Increments on each clock where `stallD`=1.
  - Saturates at all ones.
  - `stall_clr` takes priority over increment and clears the counter to 0.
- **No matching source.** An instruction whose sources match no stage passes `regDataD` unchanged.

## Timing
- **Reset** (`reset`=0, asynchronous):
  - All stage valid bits and `stall_cnt` go to 0.
  - `stallD`=0.
  - `bubbleE`=1 while `validD`=0.
  - `operandD`=`regDataD`.
- **Latency.**
  - `operandD`, `stallD` and `bubbleE` are combinational from inputs and stage records, with zero cycles of latency.
  - Stage records and `stall_cnt` update on the rising edge.
- **Record advance.** E, M and W advance every cycle; there is no back-pressure beyond `stallD`.
- **Reset mid-operation.** All in-flight records are discarded and forwarding resumes from the register file.
- **Multiple matches.** When several stages match the same source, the youngest (E) wins.
- **Independent sources.** Each source resolves independently, so two sources may forward from different stages in the same cycle.

## Test plan
- **E forward, no stall.** ADD r3 in E (`alu_resultE`=0x1234); decode reads src0=r3 -> `operandD[15:0]`=0x1234, `stallD`=0.
- **Load-use stall.** Load r5 in E, decode reads r5. Expect `stallD`=1 and `bubbleE`=1 for 1 cycle. Next cycle, with `MemReadDataM`=0xBEEF, expect operand=0xBEEF and `stallD`=0.
- **Priority.** r2 is written in E (0x0001), M (0x0002) and W (0x0003) -> operand=0x0001. With E invalidated -> 0x0002.
- **Zero register.** With `ZERO_REG`=1, the W stage writes r0=0xFFFF and decode reads r0 with `regDataD`=0 -> operand=0x0000, `stallD`=0.
- **Flush over hazard.** Load-use hazard with `flushD`=1 -> `stallD`=0, `bubbleE`=1, and E is invalid next cycle.
- **Counter.** With `CNT_W`=2, hold a hazard for 5 cycles -> `stall_cnt`=3 (saturated). Pulse `stall_clr` -> 0. Assert `reset` mid-stall -> counter=0 and `stallD`=0 immediately.
